// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, and the
// bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per bit. The integer division truncates, so the real baud rate is
  // slightly fast when CLK_FREQ is not a multiple of the baud rate.
  function automatic int bps_cnt(input int freq, input int bps);
    return freq / bps;
  endfunction

endpackage

// File: rtl/uart_send_if.sv
// Byte-in / serial-out interface of the UART transmitter.
//
// Handshake: the source presents uart_din with uart_en high; a byte is
// transferred in exactly the cycle where uart_en && tx_ready. uart_en while
// tx_ready is low is ignored (no queuing), and uart_din is only looked at in
// the transfer cycle. tx_busy is always ~tx_ready.
interface uart_send_if;
  import uart_pkg::*;

  logic        uart_en;
  logic [7:0]  uart_din;
  logic        tx_ready;
  logic        tx_busy;
  logic        tx_done;
  logic [3:0]  tx_cnt;
  logic        uart_txd;
  uart_state_e state;     // debug view of the transmitter FSM

  modport master (
    output uart_en, uart_din,
    input  tx_ready, tx_busy, tx_done, tx_cnt, uart_txd, state
  );

  modport slave (
    input  uart_en, uart_din,
    output tx_ready, tx_busy, tx_done, tx_cnt, uart_txd, state
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BPS_CNT-1 while run_i is high and emits a
// one-cycle tick on the last count of each bit. Held at zero while idle so
// every frame starts with a full-length start bit.
module uart_baud_tick #(
  parameter int BPS_CNT = 10   // must be >= 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(BPS_CNT);
  localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear when stopped, wrap at the end of a bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_send.sv
// UART transmitter: accepts one byte per handshake and sends
// start + 8 data (LSB first) + optional parity + 1 or 2 stop bits.
// Every output, including the serial line, comes straight from a flop.
module uart_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic       clk,
  input logic       rst,
  uart_send_if.slave tx_if
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  // Bit index of the final stop bit; tx_cnt counts every bit of the frame.
  localparam logic [3:0] LAST_IDX =
    4'(9 + ((PARITY != PARITY_NONE) ? 1 : 0) + STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        txd_q, txd_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        bit_tick;

  uart_baud_tick #(.BPS_CNT(BPS_CNT)) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .run_i  (state_q != ST_IDLE),
    .tick_o (bit_tick)
  );

  // Next-state and next-output logic; txd_d is the level for the next bit so
  // the line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (tx_if.uart_en) begin
          shift_d = tx_if.uart_din;
          par_d   = (PARITY == PARITY_ODD) ? ~^tx_if.uart_din : ^tx_if.uart_din;
          state_d = ST_START;
          cnt_d   = 4'd0;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          cnt_d   = 4'd1;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PAR;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PAR: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          cnt_d   = cnt_q + 4'd1;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        txd_d   = 1'b1;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      cnt_q   <= 4'd0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx_if.uart_txd = txd_q;
  assign tx_if.tx_ready = ready_q;
  assign tx_if.tx_busy  = ~ready_q;
  assign tx_if.tx_done  = done_q;
  assign tx_if.tx_cnt   = cnt_q;
  assign tx_if.state    = state_q;

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send at BPS_CNT = 10 with four configurations:
// 8N1, 8E1, 8O1 and 8N2. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_uart_send;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_send_if if_n ();
  uart_send_if if_e ();
  uart_send_if if_o ();
  uart_send_if if_s ();

  uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(0), .STOP_BITS(1))
    dut_n (.clk(clk), .rst(rst), .tx_if(if_n.slave));
  uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(2), .STOP_BITS(1))
    dut_e (.clk(clk), .rst(rst), .tx_if(if_e.slave));
  uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(1), .STOP_BITS(1))
    dut_o (.clk(clk), .rst(rst), .tx_if(if_o.slave));
  uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(0), .STOP_BITS(2))
    dut_s (.clk(clk), .rst(rst), .tx_if(if_s.slave));

  int checks = 0;
  int errors = 0;

  // Reset state of all four transmitters.
  task automatic test_reset();
    rst = 1'b1;
    if_n.uart_en = 1'b0; if_n.uart_din = 8'h00;
    if_e.uart_en = 1'b0; if_e.uart_din = 8'h00;
    if_o.uart_en = 1'b0; if_o.uart_din = 8'h00;
    if_s.uart_en = 1'b0; if_s.uart_din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (if_n.uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", if_n.uart_txd); end
    checks++; if (if_n.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if_n.tx_ready); end
    checks++; if (if_n.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if_n.tx_busy); end
    checks++; if (if_n.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", if_n.tx_done); end
    checks++; if (if_n.tx_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", if_n.tx_cnt); end
    checks++; if (if_n.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", if_n.state, ST_IDLE); end
    checks++; if ({if_e.uart_txd, if_o.uart_txd, if_s.uart_txd} !== 3'b111) begin
      errors++; $display("FAIL reset_txd_others: got %b want 111", {if_e.uart_txd, if_o.uart_txd, if_s.uart_txd});
    end
    checks++; if ({if_e.tx_ready, if_o.tx_ready, if_s.tx_ready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready_others: got %b want 111", {if_e.tx_ready, if_o.tx_ready, if_s.tx_ready});
    end
  endtask

  // Checks a full 8N1 frame on if_n, entered at the first falling edge after
  // the accept edge (k = 0). Optionally pulses uart_en with 8'h12 at cycle
  // inject_k. Leaves the caller at cycle 101.
  task automatic check_frame(input logic [9:0] exp_bits, input int inject_k, input string name);
    for (int k = 0; k < 100; k++) begin
      checks++; if (if_n.uart_txd !== exp_bits[k / 10]) begin
        errors++; $display("FAIL %s_txd k=%0d: got %b want %b", name, k, if_n.uart_txd, exp_bits[k / 10]);
      end
      checks++; if (if_n.tx_cnt !== 4'(k / 10)) begin
        errors++; $display("FAIL %s_cnt k=%0d: got %0d want %0d", name, k, if_n.tx_cnt, k / 10);
      end
      checks++; if (if_n.tx_done !== 1'b0) begin
        errors++; $display("FAIL %s_early_done k=%0d: got %b want 0", name, k, if_n.tx_done);
      end
      checks++; if ({if_n.tx_ready, if_n.tx_busy} !== 2'b01) begin
        errors++; $display("FAIL %s_ready_busy k=%0d: got %b want 01", name, k, {if_n.tx_ready, if_n.tx_busy});
      end
      if (k == 0) begin
        checks++; if (if_n.state !== ST_START) begin
          errors++; $display("FAIL %s_state_start: got %0d want %0d", name, if_n.state, ST_START);
        end
      end
      if (inject_k >= 0 && k == inject_k) begin
        if_n.uart_en  = 1'b1;
        if_n.uart_din = 8'h12;
      end
      if (inject_k >= 0 && k == inject_k + 1) if_n.uart_en = 1'b0;
      @(negedge clk);
    end
    checks++; if (if_n.tx_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, if_n.tx_done); end
    checks++; if ({if_n.tx_ready, if_n.tx_busy} !== 2'b10) begin
      errors++; $display("FAIL %s_end_ready_busy: got %b want 10", name, {if_n.tx_ready, if_n.tx_busy});
    end
    checks++; if (if_n.uart_txd !== 1'b1) begin errors++; $display("FAIL %s_gap_txd: got %b want 1", name, if_n.uart_txd); end
    checks++; if (if_n.tx_cnt !== 4'd0) begin errors++; $display("FAIL %s_end_cnt: got %0d want 0", name, if_n.tx_cnt); end
    @(negedge clk);
    checks++; if (if_n.tx_done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, if_n.tx_done); end
  endtask

  // 8'hA5, 8N1: line 0,1,0,1,0,0,1,0,1,1; done 100 cycles after accept.
  task automatic test_8n1();
    if_n.uart_din = 8'hA5;
    if_n.uart_en  = 1'b1;
    @(negedge clk);
    if_n.uart_en  = 1'b0;
    if_n.uart_din = 8'h00;
    check_frame(10'b1101001010, -1, "8n1_a5");
  endtask

  // 8'h07 on even and odd parity transmitters at once: parity bit 1 / 0.
  task automatic test_parity();
    logic [10:0] exp_e = 11'b11000001110;
    logic [10:0] exp_o = 11'b10000001110;
    if_e.uart_din = 8'h07; if_e.uart_en = 1'b1;
    if_o.uart_din = 8'h07; if_o.uart_en = 1'b1;
    @(negedge clk);
    if_e.uart_en = 1'b0;
    if_o.uart_en = 1'b0;
    for (int k = 0; k < 110; k++) begin
      checks++; if (if_e.uart_txd !== exp_e[k / 10]) begin
        errors++; $display("FAIL even_txd k=%0d: got %b want %b", k, if_e.uart_txd, exp_e[k / 10]);
      end
      checks++; if (if_o.uart_txd !== exp_o[k / 10]) begin
        errors++; $display("FAIL odd_txd k=%0d: got %b want %b", k, if_o.uart_txd, exp_o[k / 10]);
      end
      checks++; if (if_e.tx_cnt !== 4'(k / 10)) begin
        errors++; $display("FAIL even_cnt k=%0d: got %0d want %0d", k, if_e.tx_cnt, k / 10);
      end
      checks++; if ({if_e.tx_done, if_o.tx_done} !== 2'b00) begin
        errors++; $display("FAIL parity_early_done k=%0d: got %b want 00", k, {if_e.tx_done, if_o.tx_done});
      end
      if (k >= 90 && k < 100) begin
        checks++; if (if_e.state !== ST_PAR) begin
          errors++; $display("FAIL even_state_par k=%0d: got %0d want %0d", k, if_e.state, ST_PAR);
        end
      end
      @(negedge clk);
    end
    checks++; if ({if_e.tx_done, if_o.tx_done} !== 2'b11) begin
      errors++; $display("FAIL parity_done_110: got %b want 11", {if_e.tx_done, if_o.tx_done});
    end
    checks++; if ({if_e.tx_ready, if_o.tx_ready} !== 2'b11) begin
      errors++; $display("FAIL parity_ready_110: got %b want 11", {if_e.tx_ready, if_o.tx_ready});
    end
    @(negedge clk);
    checks++; if ({if_e.tx_done, if_o.tx_done} !== 2'b00) begin
      errors++; $display("FAIL parity_done_width: got %b want 00", {if_e.tx_done, if_o.tx_done});
    end
  endtask

  // 8'hFF with two stop bits: low for 10 cycles, then high for 100; done at 110.
  task automatic test_two_stop();
    if_s.uart_din = 8'hFF;
    if_s.uart_en  = 1'b1;
    @(negedge clk);
    if_s.uart_en  = 1'b0;
    for (int k = 0; k < 110; k++) begin
      checks++; if (if_s.uart_txd !== (k >= 10)) begin
        errors++; $display("FAIL stop2_txd k=%0d: got %b want %b", k, if_s.uart_txd, (k >= 10));
      end
      checks++; if (if_s.tx_cnt !== 4'(k / 10)) begin
        errors++; $display("FAIL stop2_cnt k=%0d: got %0d want %0d", k, if_s.tx_cnt, k / 10);
      end
      checks++; if (if_s.tx_done !== 1'b0) begin
        errors++; $display("FAIL stop2_early_done k=%0d: got %b want 0", k, if_s.tx_done);
      end
      @(negedge clk);
    end
    checks++; if (if_s.tx_done !== 1'b1) begin errors++; $display("FAIL stop2_done_110: got %b want 1", if_s.tx_done); end
    checks++; if (if_s.tx_ready !== 1'b1) begin errors++; $display("FAIL stop2_ready_110: got %b want 1", if_s.tx_ready); end
    @(negedge clk);
  endtask

  // uart_en held high: 8'h55 then 8'h3C with one idle-high cycle between.
  task automatic test_back_to_back();
    if_n.uart_din = 8'h55;
    if_n.uart_en  = 1'b1;
    @(negedge clk);
    if_n.uart_din = 8'h3C;
    check_frame(10'b1010101010, -1, "b2b_55");
    if_n.uart_en = 1'b0;
    check_frame(10'b1001111000, -1, "b2b_3c");
  endtask

  // uart_en pulsed with 8'h12 at cycle 35 of an 8'hA5 frame is ignored.
  task automatic test_busy_ignore();
    if_n.uart_din = 8'hA5;
    if_n.uart_en  = 1'b1;
    @(negedge clk);
    if_n.uart_en  = 1'b0;
    check_frame(10'b1101001010, 35, "ignore_a5");
    for (int k = 0; k < 20; k++) begin
      checks++; if (if_n.uart_txd !== 1'b1 || if_n.tx_ready !== 1'b1) begin
        errors++; $display("FAIL ignore_idle k=%0d: got txd=%b ready=%b want 1 1", k, if_n.uart_txd, if_n.tx_ready);
      end
      @(negedge clk);
    end
  endtask

  // Reset at cycle 45 aborts the frame; then 8'h81 goes out cleanly.
  task automatic test_reset_mid_frame();
    int done_seen = 0;
    if_n.uart_din = 8'hA5;
    if_n.uart_en  = 1'b1;
    @(negedge clk);
    if_n.uart_en  = 1'b0;
    repeat (45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (if_n.uart_txd !== 1'b1) begin errors++; $display("FAIL midrst_txd: got %b want 1", if_n.uart_txd); end
    checks++; if (if_n.tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", if_n.tx_ready); end
    checks++; if (if_n.tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", if_n.tx_busy); end
    checks++; if (if_n.tx_cnt !== 4'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", if_n.tx_cnt); end
    for (int k = 0; k < 120; k++) begin
      if (if_n.tx_done === 1'b1 || if_n.uart_txd !== 1'b1) done_seen++;
      @(negedge clk);
    end
    checks++; if (done_seen !== 0) begin
      errors++; $display("FAIL midrst_quiet: got %0d bad cycles want 0", done_seen);
    end
    if_n.uart_din = 8'h81;
    if_n.uart_en  = 1'b1;
    @(negedge clk);
    if_n.uart_en  = 1'b0;
    check_frame(10'b1100000010, -1, "after_rst_81");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
